// File: rtl/icache_ctrl_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int WORDS_PER_LINE = 4;
  localparam int OFFSET_W       = 2;
  localparam int LINE_LSB       = 3;   // byte address bit where the line index starts
  localparam int CNT_W          = 3;   // counts 0..WORDS_PER_LINE

endpackage

// File: rtl/icache_ctrl_array.sv
// Tag, valid and data storage for the instruction cache: one combinational
// line read port, one word write port and a global valid clear.
module icache_ctrl_array
  import icache_ctrl_pkg::*;
#(
  parameter int LINES  = 32,
  parameter int IDX_W  = 5,
  parameter int TAG_W  = 8,
  parameter int DATA_W = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    clr_all_i,
  input  logic [IDX_W-1:0]                        rd_idx_i,
  output logic                                    rd_valid_o,
  output logic [TAG_W-1:0]                        rd_tag_o,
  output logic [WORDS_PER_LINE-1:0][DATA_W-1:0]   rd_words_o,
  input  logic                                    wr_en_i,
  input  logic [IDX_W-1:0]                        wr_idx_i,
  input  logic [OFFSET_W-1:0]                     wr_word_i,
  input  logic [DATA_W-1:0]                       wr_data_i,
  input  logic [TAG_W-1:0]                        wr_tag_i,
  input  logic                                    wr_set_valid_i
);

  logic [LINES-1:0]                       valid_q;
  logic [TAG_W-1:0]                       tag_q  [LINES];
  logic [WORDS_PER_LINE-1:0][DATA_W-1:0]  data_q [LINES];

  // Clear wins over set so a flush on the fill's final edge leaves the line invalid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (clr_all_i) begin
      valid_q <= '0;
    end else if (wr_en_i && wr_set_valid_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      data_q[wr_idx_i][wr_word_i] <= wr_data_i;
      if (wr_set_valid_i) begin
        tag_q[wr_idx_i] <= wr_tag_i;
      end
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_words_o = data_q[rd_idx_i];

endmodule

// File: rtl/icache_ctrl.sv
// Instruction cache controller: zero-latency hit path, 4-word line fill
// against a stalling in-order memory, and deferred flush during a fill.
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int LINES  = 32,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              flush,
  output logic [DATA_W-1:0] data_out,
  output logic              done,
  output logic              hit,
  output logic              stall,
  output logic              err,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_busy,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output state_e            state_o
);

  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - LINE_LSB - IDX_W;
  localparam int LINE_W = ADDR_W - LINE_LSB;

  // Memory handshake: a read is accepted in any cycle with mem_rd=1 and
  // mem_busy=0; mem_rvalid carries one word back, in issue order.
  state_e                                 state_q, state_d;
  logic [CNT_W-1:0]                       iss_cnt_q, iss_cnt_d;
  logic [CNT_W-1:0]                       rsp_cnt_q, rsp_cnt_d;
  logic [LINE_W-1:0]                      line_q, line_d;
  logic [OFFSET_W-1:0]                    off_q, off_d;
  logic                                   flush_pend_q, flush_pend_d;

  logic [OFFSET_W-1:0]                    req_off;
  logic [IDX_W-1:0]                       req_idx;
  logic [TAG_W-1:0]                       req_tag;
  logic [IDX_W-1:0]                       rd_idx;
  logic                                   rd_valid;
  logic [TAG_W-1:0]                       rd_tag;
  logic [WORDS_PER_LINE-1:0][DATA_W-1:0]  rd_words;
  logic                                   lookup_hit;
  logic                                   clr_all;
  logic                                   wr_en;
  logic                                   wr_set_valid;

  assign req_off      = addr[LINE_LSB-1:1];
  assign req_idx      = addr[LINE_LSB+IDX_W-1:LINE_LSB];
  assign req_tag      = addr[ADDR_W-1:LINE_LSB+IDX_W];
  assign rd_idx       = (state_q == ST_IDLE) ? req_idx : line_q[IDX_W-1:0];
  assign lookup_hit   = rd_valid && (rd_tag == req_tag);
  assign wr_set_valid = (rsp_cnt_q == CNT_W'(WORDS_PER_LINE - 1));
  assign state_o      = state_q;

  icache_ctrl_array #(
    .LINES  (LINES),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk            (clk),
    .rst            (rst),
    .clr_all_i      (clr_all),
    .rd_idx_i       (rd_idx),
    .rd_valid_o     (rd_valid),
    .rd_tag_o       (rd_tag),
    .rd_words_o     (rd_words),
    .wr_en_i        (wr_en),
    .wr_idx_i       (line_q[IDX_W-1:0]),
    .wr_word_i      (rsp_cnt_q[OFFSET_W-1:0]),
    .wr_data_i      (mem_rdata),
    .wr_tag_i       (line_q[LINE_W-1:IDX_W]),
    .wr_set_valid_i (wr_set_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      iss_cnt_q    <= '0;
      rsp_cnt_q    <= '0;
      line_q       <= '0;
      off_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      iss_cnt_q    <= iss_cnt_d;
      rsp_cnt_q    <= rsp_cnt_d;
      line_q       <= line_d;
      off_q        <= off_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    iss_cnt_d    = iss_cnt_q;
    rsp_cnt_d    = rsp_cnt_q;
    line_d       = line_q;
    off_d        = off_q;
    flush_pend_d = flush_pend_q;
    data_out     = '0;
    done         = 1'b0;
    hit          = 1'b0;
    stall        = 1'b0;
    err          = 1'b0;
    mem_rd       = 1'b0;
    mem_addr     = '0;
    clr_all      = 1'b0;
    wr_en        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        flush_pend_d = 1'b0;
        clr_all      = flush;
        if (req) begin
          if (addr[0]) begin
            err  = 1'b1;
            done = 1'b1;
          end else if (lookup_hit) begin
            done     = 1'b1;
            hit      = 1'b1;
            data_out = rd_words[req_off];
          end else begin
            stall     = 1'b1;
            line_d    = addr[ADDR_W-1:LINE_LSB];
            off_d     = req_off;
            iss_cnt_d = '0;
            rsp_cnt_d = '0;
            state_d   = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        stall        = 1'b1;
        flush_pend_d = flush_pend_q | flush;
        if (!iss_cnt_q[CNT_W-1]) begin
          mem_rd   = 1'b1;
          mem_addr = {line_q, iss_cnt_q[OFFSET_W-1:0], 1'b0};
          if (!mem_busy) begin
            iss_cnt_d = iss_cnt_q + CNT_W'(1);
          end
        end
        if (mem_rvalid && !rsp_cnt_q[CNT_W-1]) begin
          wr_en     = 1'b1;
          rsp_cnt_d = rsp_cnt_q + CNT_W'(1);
          if (wr_set_valid) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done         = 1'b1;
        data_out     = rd_words[off_q];
        clr_all      = flush_pend_q | flush;
        flush_pend_d = 1'b0;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Randomized bench for icache_ctrl: behavioural cache model plus an in-order
// memory model with configurable latency and busy back-pressure.
module tb_icache_ctrl;

  localparam int LINES  = 32;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int IDX_W  = $clog2(LINES);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic              req, flush;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_out;
  logic              done, hit, stall, err, mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_busy, mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        dbg_state;

  icache_ctrl #(.LINES(LINES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .addr       (addr),
    .flush      (flush),
    .data_out   (data_out),
    .done       (done),
    .hit        (hit),
    .stall      (stall),
    .err        (err),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_busy   (mem_busy),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .state_o    (dbg_state)
  );

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory contents: a fixed bijection of the word address.
  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return (a * 16'd40503) ^ 16'h5EED;
  endfunction

  // ---------------- reference cache model ----------------
  bit mvalid [LINES];
  int mtag   [LINES];

  function automatic int idx_of(input logic [ADDR_W-1:0] a);
    return (int'(a) >> 3) % LINES;
  endfunction

  function automatic int tag_of(input logic [ADDR_W-1:0] a);
    return int'(a) >> (3 + IDX_W);
  endfunction

  task automatic model_clear();
    foreach (mvalid[i]) mvalid[i] = 1'b0;
  endtask

  // ---------------- memory model ----------------
  int                lat       = 2;      // response appears lat-1 cycles after the issue cycle
  int                busy_pct  = 0;
  int                busy_from = -100;
  int                busy_len  = 0;
  bit                spur_en   = 1'b0;
  logic [ADDR_W-1:0] exp_q     [$];      // expected mem_addr sequence
  logic [ADDR_W-1:0] iss_addr_q[$];
  int                iss_due_q [$];
  int                rsp_cyc_q [$];

  initial begin : mem_model
    mem_busy   = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        iss_addr_q.delete();
        iss_due_q.delete();
      end else if (mem_rd) begin
        if (exp_q.size() == 0) begin
          chk("mem_rd_unexpected", 32'(mem_rd), 32'd0);
        end else begin
          chk("mem_addr", 32'(mem_addr), 32'(exp_q[0]));
          if (!mem_busy) begin
            void'(exp_q.pop_front());
            iss_addr_q.push_back(mem_addr);
            iss_due_q.push_back(cyc + lat - 1);
          end
        end
      end
      @(posedge clk);
      #2;
      mem_busy = (cyc >= busy_from && cyc < busy_from + busy_len) ||
                 ($urandom_range(99) < busy_pct);
      if (rst && iss_due_q.size() > 0 && iss_due_q[0] <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(iss_addr_q.pop_front());
        void'(iss_due_q.pop_front());
        rsp_cyc_q.push_back(cyc);
      end else if (spur_en && $urandom_range(1) == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = DATA_W'($urandom);
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk_quiet(input string where);
    chk({where, "_done"},     32'(done),     32'd0);
    chk({where, "_hit"},      32'(hit),      32'd0);
    chk({where, "_stall"},    32'(stall),    32'd0);
    chk({where, "_err"},      32'(err),      32'd0);
    chk({where, "_mem_rd"},   32'(mem_rd),   32'd0);
    chk({where, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({where, "_data_out"}, 32'(data_out), 32'd0);
  endtask

  // One cycle with no request; optional flush and spurious read data.
  task automatic idle_cycle(input bit do_flush, input bit spur);
    @(posedge clk);
    #1;
    req     = 1'b0;
    addr    = ADDR_W'($urandom);
    flush   = do_flush;
    spur_en = spur;
    @(negedge clk);
    chk_quiet("idle");
    if (do_flush) model_clear();
  endtask

  // flush_at: -1 none, 0 in the lookup cycle, k>0 k cycles after the miss.
  // busy_off > 0 forces mem_busy for 3 cycles starting busy_off cycles after the miss.
  task automatic do_req(input logic [ADDR_W-1:0] a, input int flush_at,
                        input bit chk_lat, input int busy_off);
    bit exp_hit, pend, got;
    int idx, tg, miss_cyc;
    @(posedge clk);
    #1;
    spur_en = 1'b0;
    req     = 1'b1;
    addr    = a;
    flush   = (flush_at == 0);
    idx     = idx_of(a);
    tg      = tag_of(a);
    exp_hit = !a[0] && mvalid[idx] && (mtag[idx] == tg);
    @(negedge clk);
    if (flush_at == 0) model_clear();
    if (a[0]) begin
      chk("err_err",    32'(err),    32'd1);
      chk("err_done",   32'(done),   32'd1);
      chk("err_hit",    32'(hit),    32'd0);
      chk("err_stall",  32'(stall),  32'd0);
      chk("err_mem_rd", 32'(mem_rd), 32'd0);
    end else if (exp_hit) begin
      chk("hit_done",  32'(done),     32'd1);
      chk("hit_hit",   32'(hit),      32'd1);
      chk("hit_stall", 32'(stall),    32'd0);
      chk("hit_err",   32'(err),      32'd0);
      chk("hit_data",  32'(data_out), 32'(mem_word(a)));
    end else begin
      chk("miss_stall", 32'(stall), 32'd1);
      chk("miss_done",  32'(done),  32'd0);
      miss_cyc = cyc;
      rsp_cyc_q.delete();
      for (int k = 0; k < 4; k++) exp_q.push_back({a[ADDR_W-1:3], 3'b000} + ADDR_W'(2 * k));
      if (busy_off > 0) begin
        busy_from = miss_cyc + busy_off;
        busy_len  = 3;
      end
      pend = 1'b0;
      got  = 1'b0;
      for (int n = 1; n <= 200 && !got; n++) begin
        @(posedge clk);
        #1;
        flush = (flush_at > 0 && n == flush_at);
        if (flush) pend = 1'b1;
        @(negedge clk);
        if (done) begin
          got = 1'b1;
          chk("fill_hit",   32'(hit),      32'd0);
          chk("fill_stall", 32'(stall),    32'd0);
          chk("fill_data",  32'(data_out), 32'(mem_word(a)));
          if (rsp_cyc_q.size() >= 4) chk("fill_done_cycle", 32'(cyc), 32'(rsp_cyc_q[3] + 1));
          else chk("fill_rsp_count", 32'(rsp_cyc_q.size()), 32'd4);
          if (chk_lat) chk("fill_latency", 32'(cyc - miss_cyc), 32'(4 + lat + (busy_off > 0 ? 3 : 0)));
        end else begin
          chk("fill_stall_held", 32'(stall), 32'd1);
        end
      end
      if (!got) chk("fill_timeout", 32'(got), 32'd1);
      chk("fill_addr_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      busy_len  = 0;
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
      if (pend) model_clear();
    end
  endtask

  // Start a miss, then assert reset two cycles into the fill.
  task automatic reset_mid_fill(input logic [ADDR_W-1:0] a);
    @(posedge clk);
    #1;
    req  = 1'b1;
    addr = a;
    @(negedge clk);
    chk("rst_miss_stall", 32'(stall), 32'd1);
    for (int k = 0; k < 4; k++) exp_q.push_back({a[ADDR_W-1:3], 3'b000} + ADDR_W'(2 * k));
    repeat (2) begin
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    model_clear();
    @(negedge clk);
    chk_quiet("after_rst");
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int a, fa;
    rst   = 1'b0;
    req   = 1'b0;
    addr  = '0;
    flush = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_cycle(1'b0, 1'b0);

    // Directed: first fill, hit, busy stall, conflict, flush in fill, error, reset.
    lat = 2;
    do_req(16'h0010, -1, 1'b1, 0);
    idle_cycle(1'b0, 1'b1);
    do_req(16'h0014, -1, 1'b0, 0);
    idle_cycle(1'b0, 1'b0);
    do_req(16'h0048, -1, 1'b1, 2);
    idle_cycle(1'b0, 1'b0);
    do_req(16'h0110, -1, 1'b1, 0);
    idle_cycle(1'b0, 1'b0);
    do_req(16'h0010, -1, 1'b1, 0);
    idle_cycle(1'b0, 1'b0);
    do_req(16'h0020, 2, 1'b1, 0);
    idle_cycle(1'b0, 1'b0);
    do_req(16'h0020, -1, 1'b1, 0);
    idle_cycle(1'b0, 1'b0);
    do_req(16'h0026, 0, 1'b0, 0);
    idle_cycle(1'b0, 1'b0);
    do_req(16'h0003, -1, 1'b0, 0);
    idle_cycle(1'b0, 1'b0);
    do_req(16'h0010, -1, 1'b0, 0);
    idle_cycle(1'b0, 1'b0);
    reset_mid_fill(16'h0040);
    do_req(16'h0014, -1, 1'b1, 0);
    idle_cycle(1'b0, 1'b0);
    do_req(16'h0110, -1, 1'b1, 0);
    idle_cycle(1'b0, 1'b0);

    // Random: small address pool so hits, conflicts and refills all occur.
    for (int i = 0; i < 80; i++) begin
      lat      = $urandom_range(5, 2);
      busy_pct = ($urandom_range(1) == 0) ? 0 : 30;
      a  = ($urandom_range(2) << 8) | ($urandom_range(3) << 3) | ($urandom_range(3) << 1);
      if ($urandom_range(9) == 0) a = a | 1;
      fa = -1;
      case ($urandom_range(7))
        0: fa = 0;
        1: fa = $urandom_range(8, 1);
        default: fa = -1;
      endcase
      do_req(ADDR_W'(a), fa, 1'b0, 0);
      idle_cycle($urandom_range(11) == 0, 1'b1);
      if ($urandom_range(3) == 0) idle_cycle(1'b0, 1'b1);
    end
    busy_pct = 0;
    idle_cycle(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
